// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_KILL  = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus between fetch_ctrl (master) and memory (slave).
interface fetch_ctrl_if;
  // imem_req is held with imem_addr stable until a cycle with imem_ack=1;
  // imem_ack may rise in the same cycle as imem_req, and imem_rdata is valid only with imem_ack.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface : fetch_ctrl_if

// File: rtl/fetch_buf.sv
// IF/ID pipeline register: load has priority over flush; otherwise contents hold.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule : fetch_buf

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, redirect/kill handling, IF/ID register.
// Build option: define FETCH_DELAY_SLOT_EN to keep the IF register across a redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_ctrl_if.master        imem,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                fetch_err,
  output fetch_state_e        dbg_state
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit FLUSH_ON_REDIRECT = 1'b0;
`else
  localparam bit FLUSH_ON_REDIRECT = 1'b1;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic         fetch_err_q, fetch_err_d;
  logic         err_pend_q, err_pend_d;
  logic         buf_load, buf_flush;
  logic         redir_ok, redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    fetch_err_d   = fetch_err_q;
    err_pend_d    = err_pend_q;
    imem.imem_req = 1'b0;
    buf_load      = 1'b0;
    buf_flush     = if_valid && !stall;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (redir_bad) begin
          fetch_err_d = 1'b1;
          buf_flush   = 1'b1;
          state_d     = ST_ERR;
        end else if (redir_ok) begin
          pc_d      = redirect_pc;
          buf_flush = FLUSH_ON_REDIRECT;
          state_d   = ST_FETCH;
        end else if (state_q == ST_IDLE || !stall) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (redir_bad) begin
          fetch_err_d = 1'b1;
          buf_flush   = 1'b1;
          // Without an ack the request is still outstanding and must drain via KILL.
          err_pend_d  = !imem.imem_ack;
          state_d     = imem.imem_ack ? ST_ERR : ST_KILL;
        end else if (redir_ok) begin
          buf_flush = FLUSH_ON_REDIRECT;
          if (imem.imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            pending_pc_d = redirect_pc;
            state_d      = ST_KILL;
          end
        end else if (imem.imem_ack) begin
          buf_load = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = stall ? ST_HOLD : ST_FETCH;
        end
      end
      ST_KILL: begin
        imem.imem_req = 1'b1;
        if (redir_bad) begin
          fetch_err_d = 1'b1;
          buf_flush   = 1'b1;
          err_pend_d  = 1'b1;
        end else if (redir_ok && !err_pend_q) begin
          pending_pc_d = redirect_pc;
          buf_flush    = FLUSH_ON_REDIRECT;
        end
        if (imem.imem_ack) begin
          if (err_pend_q || redir_bad) begin
            state_d = ST_ERR;
          end else begin
            pc_d    = redir_ok ? redirect_pc : pending_pc_q;
            state_d = ST_FETCH;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      fetch_err_q  <= 1'b0;
      err_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      fetch_err_q  <= fetch_err_d;
      err_pend_q   <= err_pend_d;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .flush      (buf_flush),
    .load_pc    (pc_q),
    .load_instr (imem.imem_rdata),
    .valid_o    (if_valid),
    .pc_o       (if_pc),
    .instr_o    (if_instr)
  );

  assign imem.imem_addr = pc_q;
  assign fetch_err      = fetch_err_q;
  assign dbg_state      = state_q;

endmodule : fetch_ctrl
